// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte valid/ready handshake feeding uart_tx
interface uart_tx_if;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter, one UART_clk per bit, STOP_BITS 1 or 2
// Optional input FIFO of FIFO_DEPTH bytes is compiled in when UART_TX_FIFO_EN is defined.
module uart_tx #(
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      UART_clk,
    input  logic      rst_n,
    uart_tx_if.slave  in_if,
    output logic      tx_data,
    output logic      busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // An illegal parameter set keeps the block permanently not-ready rather than
    // emitting malformed frames.
    localparam bit CFG_OK = ((STOP_BITS == 1) || (STOP_BITS == 2)) && (FIFO_DEPTH >= 2) &&
                            ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    state_t     state, state_nxt;
    logic [7:0] shift, shift_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic       stop_cnt, stop_cnt_nxt;
    logic       tx_nxt;
    logic       final_stop;
    logic       load;
    logic [7:0] load_byte;

    assign final_stop = (state == STOP) && (stop_cnt == LAST_STOP);

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_if.ready = !fifo_full && CFG_OK;
    assign push        = in_if.valid && in_if.ready;
    // Pop decision uses registered pointers, so a fresh push is visible one edge later.
    assign load        = !fifo_empty && ((state == IDLE) || final_stop);
    assign load_byte   = mem[rd_ptr[AW-1:0]];
    assign busy        = (state != IDLE) || !fifo_empty;

    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge UART_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_if.data_in;
    end
`else
    assign in_if.ready = ((state == IDLE) || final_stop) && CFG_OK;
    assign load        = in_if.valid && in_if.ready;
    assign load_byte   = in_if.data_in;
    assign busy        = (state != IDLE);
`endif

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        bit_idx_nxt  = bit_idx;
        stop_cnt_nxt = stop_cnt;
        tx_nxt       = 1'b1;
        case (state)
            IDLE: begin
                if (load) begin
                    shift_nxt = load_byte;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt      = shift[0];
                shift_nxt   = {1'b0, shift[7:1]};
                bit_idx_nxt = 3'd0;
                state_nxt   = DATA;
            end
            DATA: begin
                if (bit_idx == 3'd7) begin
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = STOP;
                end else begin
                    tx_nxt      = shift[0];
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (final_stop) begin
                    stop_cnt_nxt = 1'b0;
                    // Chaining straight into the next start bit keeps the line gap-free.
                    if (load) begin
                        shift_nxt = load_byte;
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    stop_cnt_nxt = stop_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx_data  <= 1'b1;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            bit_idx  <= bit_idx_nxt;
            stop_cnt <= stop_cnt_nxt;
            tx_data  <= tx_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - table-driven bench for uart_tx with a serial receiver model
module tb_uart_tx;
    logic UART_clk = 1'b0;
    logic rst_n    = 1'b0;
    logic tx_data, busy, tx_data2, busy2;

    uart_tx_if if1();
    uart_tx_if if2();

    uart_tx #(.STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .UART_clk(UART_clk), .rst_n(rst_n), .in_if(if1), .tx_data(tx_data), .busy(busy));
    uart_tx #(.STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .UART_clk(UART_clk), .rst_n(rst_n), .in_if(if2), .tx_data(tx_data2), .busy(busy2));

    always #5 UART_clk = ~UART_clk;

`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            if2.valid = v; if2.data_in = d;
        end else begin
            if1.valid = v; if1.data_in = d;
        end
    endtask

    function automatic logic cur_ready(input bit sel);
        return sel ? if2.ready : if1.ready;
    endfunction

    function automatic logic cur_line(input bit sel);
        return sel ? tx_data2 : tx_data;
    endfunction

    // Offer npush bytes (b0 then b1), capturing the line from the first start bit onward.
    task automatic run_seq(input bit sel, input int npush, input logic [7:0] b0,
                           input logic [7:0] b1, input int nsamp, output logic [31:0] cap);
        int   acc, ns, skip, guard;
        logic go;
        acc = 0; ns = 0; skip = LAT; guard = 0; cap = '0;
        set_in(sel, 1'b1, b0);
        while (ns < nsamp && guard < 300) begin
            go = (acc < npush) && cur_ready(sel);
            @(posedge UART_clk);
            @(negedge UART_clk);
            guard++;
            if (go) begin
                acc++;
                if (acc < npush) set_in(sel, 1'b1, b1);
                else             set_in(sel, 1'b0, 8'h00);
            end
            if (acc >= 1) begin
                if (skip > 0) skip--;
                else begin
                    cap = {cap[30:0], cur_line(sel)};
                    ns++;
                end
            end
        end
        if (ns < nsamp) check("run_seq timeout", 32'(ns), 32'(nsamp));
        set_in(sel, 1'b0, 8'h00);
    endtask

    task automatic check_idle(input string tag);
        @(posedge UART_clk);
        @(negedge UART_clk);
        check({tag, " tx_data idle"}, 32'(tx_data), 32'd1);
        check({tag, " busy idle"},    32'(busy),    32'd0);
        check({tag, " ready idle"},   32'(if1.ready), 32'd1);
    endtask

    // Serial receiver model sampling once per bit cycle.
    initial begin
        int         phase;
        logic [7:0] sh;
        phase = 0;
        sh    = '0;
        forever begin
            @(negedge UART_clk);
            if (!rst_n) phase = 0;
            else if (phase == 0) begin
                if (!tx_data) phase = 1;
            end else if (phase <= 8) begin
                sh = {tx_data, sh[7:1]};
                phase++;
            end else begin
                if (tx_data) rx_q.push_back(sh);
                phase = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] cap;
        vec_t        vecs[5];
        int          g;

        vecs[0] = '{8'hA5, 10'b0101001011};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'h3C, 10'b0001111001};
        vecs[4] = '{8'h81, 10'b0100000011};

        set_in(1'b0, 1'b0, 8'h00);
        set_in(1'b1, 1'b0, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge UART_clk);
        check("reset tx_data",  32'(tx_data),   32'd1);
        check("reset busy",     32'(busy),      32'd0);
        check("reset ready",    32'(if1.ready), 32'd1);
        check("reset tx_data2", 32'(tx_data2),  32'd1);
        rst_n = 1'b1;
        @(negedge UART_clk);

        foreach (vecs[i]) begin
            run_seq(1'b0, 1, vecs[i].data, 8'h00, 10, cap);
            check($sformatf("frame 0x%02h", vecs[i].data), 32'(cap[9:0]), 32'(vecs[i].line));
            check_idle($sformatf("after 0x%02h", vecs[i].data));
        end

        rx_q.delete();
        run_seq(1'b0, 1, 8'h3C, 8'h00, 10, cap);
        check_idle("loop 0x3C");
        run_seq(1'b0, 1, 8'h81, 8'h00, 10, cap);
        repeat (2) @(negedge UART_clk);
        check("loop rx count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("loop rx byte0", 32'(rx_q[0]), 32'h3C);
            check("loop rx byte1", 32'(rx_q[1]), 32'h81);
        end

        run_seq(1'b0, 2, 8'h00, 8'hFF, 20, cap);
        check("back-to-back 0x00,0xFF", 32'(cap[19:0]), 32'(20'b0000000001_0111111111));
        check_idle("after back-to-back");

        set_in(1'b0, 1'b1, 8'h55);
        @(posedge UART_clk);
        @(negedge UART_clk);
        set_in(1'b0, 1'b0, 8'h00);
        repeat (4 + LAT) @(negedge UART_clk);
        check("0x55 data bit3",  32'(tx_data),   32'd0);
        check("ready mid-frame", 32'(if1.ready), 32'(LAT));
        check("busy mid-frame",  32'(busy),      32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset tx_data", 32'(tx_data), 32'd1);
        check("async reset busy",    32'(busy),    32'd0);
        repeat (2) @(negedge UART_clk);
        check("held reset tx_data",  32'(tx_data), 32'd1);
        rst_n = 1'b1;
        @(negedge UART_clk);
        check("post-reset line quiet", 32'(tx_data), 32'd1);
        run_seq(1'b0, 1, 8'h0F, 8'h00, 10, cap);
        check("frame 0x0F after reset", 32'(cap[9:0]), 32'(10'b0111100001));
        check_idle("after 0x0F");

`ifdef UART_TX_FIFO_EN
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fifo ready before push %0d", i + 1), 32'(if1.ready), 32'(i < 5));
            set_in(1'b0, 1'b1, 8'(i + 1));
            if (i < 5) begin
                @(posedge UART_clk);
                @(negedge UART_clk);
            end
        end
        g = 0;
        while (!if1.ready && g < 50) begin
            @(posedge UART_clk);
            @(negedge UART_clk);
            g++;
        end
        check("fifo 6th byte wait cycles", 32'(g), 32'd7);
        @(posedge UART_clk);
        @(negedge UART_clk);
        set_in(1'b0, 1'b0, 8'h00);
        g = 0;
        while ((busy || rx_q.size() < 6) && g < 120) begin
            @(negedge UART_clk);
            g++;
        end
        repeat (2) @(negedge UART_clk);
        check("fifo rx count", 32'(rx_q.size()), 32'd6);
        if (rx_q.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("fifo rx byte%0d", i), 32'(rx_q[i]), 32'(i + 1));
        end
`endif

        run_seq(1'b1, 2, 8'hFF, 8'hFF, 12, cap);
        check("two stop bits 0xFF", 32'(cap[11:0]), 32'(12'b0_11111111_11_0));
        g = 0;
        while (busy2 && g < 40) begin
            @(negedge UART_clk);
            g++;
        end
        check("stop2 busy drains", 32'(busy2),    32'd0);
        check("stop2 line idle",   32'(tx_data2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
